// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order; anode values are
// active-low one-hot with bit 0 selecting the rightmost digit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE   = 4'hF;
  localparam logic [3:0] ILLEGAL_CODE = 4'hE;

  localparam logic [3:0] ANODE_D0 = 4'b1110;
  localparam logic [3:0] ANODE_D1 = 4'b1101;
  localparam logic [3:0] ANODE_D2 = 4'b1011;
  localparam logic [3:0] ANODE_D3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the shared segment table: pattern -> BCD code.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       illegal
);

  // Any pattern that is neither a digit nor blank decodes to the illegal code
  always_comb begin
    code    = ILLEGAL_CODE;
    illegal = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = BLANK_CODE;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed seven-segment scan bus and rebuilds the four shown
// digits. Each anode/seg pair must hold still before it is captured, so scan
// transitions and glitches never reach the frame.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic        frame_done,
  output logic        frame_valid,
  output logic        stable,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] STABLE_MAX  = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [6:0]    seg_s1, seg_s2, seg_prev;
  logic [3:0]    anode_s1, anode_s2, anode_prev;
  logic          changed;
  logic [SW-1:0] settle_cnt;

  scan_state_t   state_q, state_d;
  logic          capture;

  logic [3:0]    dec_code;
  logic          dec_illegal;
  logic          anode_ok;
  logic [1:0]    anode_idx;

  logic [3:0]    mask;
  logic [3:0]    mask_base;
  logic [15:0]   shadow;
  logic          frame_complete;

  logic [MW-1:0] match_cnt, match_next;
  logic [TW-1:0] to_cnt;

  assign changed        = (seg_s2 != seg_prev) || (anode_s2 != anode_prev);
  assign capture        = (state_q == ST_CAPTURE);
  assign frame_complete = (mask == 4'b1111);
  assign mask_base      = frame_complete ? 4'b0000 : mask;

  // The previous sample is the settled value, so the decoder looks at it
  seg7_decode u_decode (
    .seg     (seg_prev),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // Two-flop synchroniser, previous-sample register and saturating settle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1     <= SEG_BLANK;
      seg_s2     <= SEG_BLANK;
      seg_prev   <= SEG_BLANK;
      anode_s1   <= 4'b1111;
      anode_s2   <= 4'b1111;
      anode_prev <= 4'b1111;
      settle_cnt <= '0;
    end else begin
      seg_s1     <= seg;
      seg_s2     <= seg_s1;
      seg_prev   <= seg_s2;
      anode_s1   <= anode;
      anode_s2   <= anode_s1;
      anode_prev <= anode_s2;
      if (changed) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + SW'(1);
      end
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // CAPTURE lasts one cycle as the count reaches its limit; HOLD blocks recapture
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:    if (!changed && settle_cnt == SETTLE_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = changed ? ST_WAIT : ST_HOLD;
      ST_HOLD:    if (changed) state_d = ST_WAIT;
      default:    state_d = ST_WAIT;
    endcase
  end

  // Map the settled anode to a slot; anything but a single low bit is rejected
  always_comb begin
    anode_ok  = 1'b1;
    anode_idx = 2'd0;
    case (anode_prev)
      ANODE_D0: anode_idx = 2'd0;
      ANODE_D1: anode_idx = 2'd1;
      ANODE_D2: anode_idx = 2'd2;
      ANODE_D3: anode_idx = 2'd3;
      default:  anode_ok  = 1'b0;
    endcase
  end

  // Shadow/mask update; a capture in the completion cycle lands in the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= 16'hFFFF;
      mask        <= 4'b0000;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      mask <= mask_base;
      if (capture) begin
        if (anode_ok) begin
          shadow[{anode_idx, 2'b00} +: 4] <= dec_code;
          mask <= mask_base | (4'b0001 << anode_idx);
          if (dec_illegal) begin
            err_pattern <= 1'b1;
          end
        end else begin
          err_anode <= 1'b1;
        end
      end
    end
  end

  // Next match count: consecutive identical frames, saturating
  always_comb begin
    match_next = MW'(1);
    if (shadow == digits) begin
      match_next = (match_cnt == STABLE_MAX) ? match_cnt : match_cnt + MW'(1);
    end
  end

  // Publish frames, track stability and drop validity when the scan stops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'hFFFF;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      stable      <= 1'b0;
      match_cnt   <= '0;
      to_cnt      <= '0;
    end else begin
      frame_done <= frame_complete;
      if (frame_complete) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        match_cnt   <= match_next;
        stable      <= (match_next == STABLE_MAX);
        to_cnt      <= '0;
      end else if (to_cnt == TIMEOUT_MAX) begin
        frame_valid <= 1'b0;
        stable      <= 1'b0;
        match_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule
